// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
// Segment bit order everywhere is {g,f,e,d,c,b,a}.
package seg7_pkg;

    // Active-high gfedcba patterns for hex digits 0..F.
    localparam logic [6:0] GLYPH_HEX [16] = '{
        7'h3F, // 0
        7'h06, // 1
        7'h5B, // 2
        7'h4F, // 3
        7'h66, // 4
        7'h6D, // 5
        7'h7D, // 6
        7'h07, // 7
        7'h7F, // 8
        7'h6F, // 9
        7'h77, // A
        7'h7C, // b
        7'h39, // C
        7'h5E, // d
        7'h79, // E
        7'h71  // F
    };

    // Active-low value that turns every segment off.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Bits needed to hold 0..n-1; never less than 1 so 1-entry ranges still get a bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_hex_glyph.sv
// Combinational hex-nibble to active-low 7-segment decoder.
module seg7_hex_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Table lookup, inverted for common-anode (segment lit when driven low).
    always_comb begin
        seg_n = ~GLYPH_HEX[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver.
// A load strobe captures the inputs into a pending set; the pending set is
// promoted to the displayed (shadow) set only when the scan wraps to digit 0,
// so a frame is always drawn from a single consistent snapshot.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blink_en,
    input  logic                    blank_lz,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [N_DIGITS-1:0]     an_n,
    output logic                    frame_tick
);

    localparam int RW = idx_width(REFRESH_DIV);
    localparam int IW = idx_width(N_DIGITS);
    localparam int FW = idx_width(BLINK_FRAMES);

    localparam logic [RW-1:0] RC_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [FW-1:0] FC_LAST  = FW'(BLINK_FRAMES - 1);

    // Scan position
    logic [RW-1:0] rc;
    logic [IW-1:0] idx;
    logic          rc_last;
    logic          wrap;

    // Blink timing
    logic [FW-1:0] fc;
    logic          blink_phase;

    // Pending (written by load) and shadow (displayed) snapshots
    logic [4*N_DIGITS-1:0] pend_value;
    logic [N_DIGITS-1:0]   pend_dp;
    logic [N_DIGITS-1:0]   pend_blink;
    logic                  pend_valid;
    logic [4*N_DIGITS-1:0] shd_value;
    logic [N_DIGITS-1:0]   shd_dp;
    logic [N_DIGITS-1:0]   shd_blink;

    // Current-digit decode
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blink;
    logic                cur_lz;
    logic [N_DIGITS-1:0] lz_mask;
    logic [N_DIGITS-1:0] an_next;
    logic                upper_zero;
    logic                blank;
    logic [6:0]          glyph_n;

    // The frame boundary is the terminal refresh count of the last digit:
    // on that edge the index returns to 0.
    assign rc_last = (rc == RC_LAST);
    assign wrap    = rc_last && (idx == IDX_LAST);

    // Refresh counter and digit index; index advances once per refresh slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc  <= '0;
            idx <= '0;
        end else if (rc_last) begin
            rc  <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            rc <= rc + 1'b1;
        end
    end

    // Frame counter; blink phase flips every BLINK_FRAMES frame boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc          <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (fc == FC_LAST) begin
                fc          <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                fc <= fc + 1'b1;
            end
        end
    end

    // Pending capture and frame-aligned promotion to shadow. A load on the
    // boundary edge still lets the previous pending set commit; the new load
    // then waits in pending for the following boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blink <= '0;
            pend_valid <= 1'b0;
            shd_value  <= '0;
            shd_dp     <= '0;
            shd_blink  <= '0;
        end else begin
            if (wrap && pend_valid) begin
                shd_value <= pend_value;
                shd_dp    <= pend_dp;
                shd_blink <= pend_blink;
            end
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp_in;
                pend_blink <= blink_en;
                pend_valid <= 1'b1;
            end else if (wrap) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Leading-zero mask: walk from the top nibble down while everything seen
    // so far is zero. Digit 0 is excluded so a zero value still shows "0".
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (shd_value[4*k +: 4] == 4'h0);
            lz_mask[k] = blank_lz & upper_zero & (k != 0);
        end
    end

    // Select the shadow data and anode for the digit currently being scanned.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        an_next   = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib    = shd_value[4*k +: 4];
                cur_dp     = shd_dp[k];
                cur_blink  = shd_blink[k];
                cur_lz     = lz_mask[k];
                an_next[k] = 1'b0;
            end
        end
    end

    seg7_hex_glyph u_glyph (
        .nibble (cur_nib),
        .seg_n  (glyph_n)
    );

    // A blanked digit keeps its anode driven but shows no segments or point.
    assign blank = (cur_blink & blink_phase) | cur_lz;

    // Registered pin outputs; they follow the index by one clock and change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_tick <= 1'b0;
        end else begin
            seg_n      <= blank ? SEG_OFF : glyph_n;
            dp_n       <= blank | ~cur_dp;
            an_n       <= an_next;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
// One frame is 16 clocks; cyc counts rising edges since reset release.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int BF = 2;
    localparam int FRAME = N * RD;

    logic          clk;
    logic          rst_n;
    logic [4*N-1:0] value;
    logic          load;
    logic [N-1:0]  dp_in;
    logic [N-1:0]  blink_en;
    logic          blank_lz;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [N-1:0]  an_n;
    logic          frame_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS     (N),
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .dp_in      (dp_in),
        .blink_en   (blink_en),
        .blank_lz   (blank_lz),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    // Comparison point
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks: one rising edge, then settle on the falling edge
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        value    = v;
        dp_in    = dp;
        blink_en = bl;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk($sformatf("%s_seg", tag), {9'd0, seg_n}, 16'h007F);
        chk($sformatf("%s_dp", tag), {15'd0, dp_n}, 16'h0001);
        chk($sformatf("%s_an", tag), {12'd0, an_n}, 16'h000F);
        chk($sformatf("%s_ft", tag), {15'd0, frame_tick}, 16'h0000);
    endtask

    // Scan one full frame starting at a frame boundary. p0..p3 are the
    // active-high patterns expected on digits 0..3 (0 = blanked), dpn the
    // expected dp_n per digit.
    task automatic check_frame(input string tag, input logic [6:0] p0, input logic [6:0] p1,
                               input logic [6:0] p2, input logic [6:0] p3, input logic [3:0] dpn);
        logic [6:0] pats [4];
        logic [3:0] one;
        logic       ft_exp;
        pats[0] = p0;
        pats[1] = p1;
        pats[2] = p2;
        pats[3] = p3;
        for (int d = 0; d < N; d++) begin
            one = 4'b0001 << d;
            for (int t = 0; t < RD; t++) begin
                tick();
                ft_exp = ((cyc % FRAME) == 0);
                chk($sformatf("%s_an_d%0d_t%0d", tag, d, t), {12'd0, an_n}, {12'd0, ~one});
                chk($sformatf("%s_ft_d%0d_t%0d", tag, d, t), {15'd0, frame_tick}, {15'd0, ft_exp});
                if (t == 0) begin
                    chk($sformatf("%s_seg_d%0d", tag, d), {9'd0, seg_n}, {9'd0, ~pats[d]});
                    chk($sformatf("%s_dp_d%0d", tag, d), {15'd0, dp_n}, {15'd0, dpn[d]});
                end
            end
        end
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence
    initial begin
        rst_n    = 1'b0;
        value    = '0;
        load     = 1'b0;
        dp_in    = '0;
        blink_en = '0;
        blank_lz = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_hold");
        rst_n = 1'b1;
        cyc   = 0;

        // Shadow is zero after reset: "0000", first lit digit an_n=E
        check_frame("zero_f0", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'hF);

        // Basic load, shown from the next frame
        do_load(16'h12AF, 4'h0, 4'h0);
        run_to(2 * FRAME);
        check_frame("hex_12af", 7'h71, 7'h77, 7'h5B, 7'h06, 4'hF);

        // Two loads in one frame: last wins
        do_load(16'h0000, 4'h0, 4'h0);
        repeat (3) tick();
        do_load(16'h00F0, 4'h0, 4'h0);
        run_to(4 * FRAME);
        check_frame("last_wins", 7'h3F, 7'h71, 7'h3F, 7'h3F, 4'hF);

        // Leading-zero blanking is a live level
        blank_lz = 1'b1;
        check_frame("lz_blank", 7'h3F, 7'h71, 7'h00, 7'h00, 4'hF);
        blank_lz = 1'b0;

        // Load on the boundary cycle: earlier pending commits first
        run_to(6 * FRAME + 4);
        do_load(16'h789C, 4'h0, 4'h0);
        run_to(7 * FRAME - 1);
        do_load(16'h3456, 4'h0, 4'h0);
        check_frame("bnd_old", 7'h39, 7'h6F, 7'h7F, 7'h07, 4'hF);
        check_frame("bnd_new", 7'h7D, 7'h6D, 7'h66, 7'h4F, 4'hF);

        // Blink on digit 1, decimal point on digit 2
        do_load(16'h4321, 4'b0100, 4'b0010);
        run_to(10 * FRAME);
        check_frame("blink_dark0", 7'h06, 7'h00, 7'h4F, 7'h66, 4'b1011);
        check_frame("blink_dark1", 7'h06, 7'h00, 7'h4F, 7'h66, 4'b1011);
        check_frame("blink_lit0", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b1011);
        check_frame("blink_lit1", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b1011);

        // Reset mid-scan with a pending load
        run_to(14 * FRAME + 6);
        do_load(16'hBEEF, 4'hF, 4'h0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset_mid");
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset_mid_hold");
        rst_n = 1'b1;
        cyc   = 0;
        check_frame("post_rst0", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'hF);
        check_frame("post_rst1", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
